// File: rtl/adder_exerciser_pkg.sv
// Shared definitions for the pin-level adder exerciser.
//   state_t      : exerciser FSM states
//   LFSR_TAPS    : Fibonacci tap mask for taps 16, 14, 13, 11
//   DEFAULT_SEED : LFSR start value used when no SEED override is given
//   ERR_SAT      : ceiling of the mismatch counter
//   lfsr_next()  : one LFSR shift (left shift, feedback into bit 0)
//   sat_inc()    : saturating increment of the mismatch counter
package adder_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [7:0]  ERR_SAT      = 8'd255;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == ERR_SAT) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/adder_pin_exerciser_lfsr16.sv
// 16-bit Fibonacci LFSR producing the operand stream.
//   clk   in  : clock
//   rst   in  : synchronous active-high reset, state returns to seed
//   load  in  : reload seed (takes priority over step)
//   step  in  : advance one position
//   seed  in  : start value, must be non-zero
//   state out : current LFSR contents
module lfsr16
  import adder_exerciser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // LFSR state register: reset/load to seed, otherwise optional single step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/adder_pin_exerciser.sv
// Driving and checking end of a pin-level adder (sum = a + b mod 2^WIDTH).
// Pseudo-random operand pairs are driven out, the returned sum is sampled
// LATENCY cycles later and compared against the locally computed sum.
//   clk, rst        in  : clock, synchronous active-high reset
//   start           in  : level-sampled run request, honoured in IDLE/DONE
//   op_a, op_b      out : operands to the adder
//   sum_in          in  : sum returned by the adder
//   busy            out : run in progress
//   done            out : run finished, held until restart or reset
//   pass            out : valid with done, high when no mismatch was seen
//   err_count       out : mismatch count, saturating at 255
//   first_err_valid out : a mismatch has been captured this run
//   first_err_idx   out : vector index of the first mismatch
module adder_pin_exerciser
  import adder_exerciser_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          LATENCY     = 0,
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             first_err_valid,
  output logic [15:0]      first_err_idx
);

  localparam logic [3:0]  LAT_C    = 4'(LATENCY);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [15:0]     idx_r;
  logic [15:0]     idx_nxt_s;
  logic [3:0]      wait_r;
  logic [3:0]      wait_nxt_s;
  logic [15:0]     lfsr_state_s;
  logic [15:0]     lfsr_ahead_s;
  logic            start_ok_s;
  logic            compare_s;
  logic            last_s;
  logic            mismatch_s;
  logic [WIDTH-1:0] expected_s;
  logic [7:0]      err_upd_s;

  logic [WIDTH-1:0] op_a_nxt_s;
  logic [WIDTH-1:0] op_b_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             pass_nxt_s;
  logic [7:0]       err_count_nxt_s;
  logic             first_err_valid_nxt_s;
  logic [15:0]      first_err_idx_nxt_s;

  // A start request is only honoured outside an active run
  assign start_ok_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign compare_s    = (state_r == RUN) && (wait_r == LAT_C);
  assign last_s       = (idx_r == LAST_IDX);
  assign expected_s   = WIDTH'(op_a + op_b);
  assign mismatch_s   = compare_s && (sum_in != expected_s);
  assign err_upd_s    = mismatch_s ? sat_inc(err_count) : err_count;
  // Operands are registered, so the next pair is taken from the value the
  // LFSR will hold after this step
  assign lfsr_ahead_s = lfsr_next(lfsr_state_s);

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok_s),
    .step  (compare_s && !last_s),
    .seed  (SEED),
    .state (lfsr_state_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (compare_s && last_s) state_nxt_s = DONE;
        else                     state_nxt_s = RUN;
      end
      DONE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of counters, operands and status outputs
  always_comb begin
    idx_nxt_s             = idx_r;
    wait_nxt_s            = wait_r;
    op_a_nxt_s            = op_a;
    op_b_nxt_s            = op_b;
    busy_nxt_s            = busy;
    done_nxt_s            = done;
    pass_nxt_s            = pass;
    err_count_nxt_s       = err_count;
    first_err_valid_nxt_s = first_err_valid;
    first_err_idx_nxt_s   = first_err_idx;
    if (start_ok_s) begin
      // Vector 0 comes straight from the seed, matching the LFSR reload
      op_a_nxt_s            = SEED[15 -: WIDTH];
      op_b_nxt_s            = SEED[WIDTH-1:0];
      idx_nxt_s             = 16'd0;
      wait_nxt_s            = 4'd0;
      busy_nxt_s            = 1'b1;
      done_nxt_s            = 1'b0;
      pass_nxt_s            = 1'b0;
      err_count_nxt_s       = 8'd0;
      first_err_valid_nxt_s = 1'b0;
      first_err_idx_nxt_s   = 16'd0;
    end else if (state_r == RUN) begin
      if (!compare_s) begin
        wait_nxt_s = wait_r + 4'd1;
      end else begin
        err_count_nxt_s = err_upd_s;
        if (mismatch_s && !first_err_valid) begin
          first_err_valid_nxt_s = 1'b1;
          first_err_idx_nxt_s   = idx_r;
        end else begin
          first_err_valid_nxt_s = first_err_valid;
          first_err_idx_nxt_s   = first_err_idx;
        end
        if (last_s) begin
          // pass folds in the final vector's own compare result
          busy_nxt_s = 1'b0;
          done_nxt_s = 1'b1;
          pass_nxt_s = (err_upd_s == 8'd0);
          op_a_nxt_s = {WIDTH{1'b0}};
          op_b_nxt_s = {WIDTH{1'b0}};
        end else begin
          op_a_nxt_s = lfsr_ahead_s[15 -: WIDTH];
          op_b_nxt_s = lfsr_ahead_s[WIDTH-1:0];
          idx_nxt_s  = idx_r + 16'd1;
          wait_nxt_s = 4'd0;
        end
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r           <= 16'd0;
      wait_r          <= 4'd0;
      op_a            <= {WIDTH{1'b0}};
      op_b            <= {WIDTH{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 8'd0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 16'd0;
    end else begin
      idx_r           <= idx_nxt_s;
      wait_r          <= wait_nxt_s;
      op_a            <= op_a_nxt_s;
      op_b            <= op_b_nxt_s;
      busy            <= busy_nxt_s;
      done            <= done_nxt_s;
      pass            <= pass_nxt_s;
      err_count       <= err_count_nxt_s;
      first_err_valid <= first_err_valid_nxt_s;
      first_err_idx   <= first_err_idx_nxt_s;
    end
  end

endmodule

// File: tb/tb_adder_pin_exerciser.sv
// Directed bench for adder_pin_exerciser. Four instances run side by side:
//   u0 : LATENCY 0, 256 vectors, combinational loopback (clean or bit0 stuck)
//   u1 : LATENCY 2, 256 vectors, two-stage registered adder
//   u2 : LATENCY 1, 256 vectors, two-stage registered adder (mismatched)
//   u3 : LATENCY 0, 300 vectors, sum tied to zero
module tb_adder_pin_exerciser;
  import adder_exerciser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stuck = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic [7:0] a0, b0, s0, ec0, a1, b1, s1, ec1, a2, b2, s2, ec2, a3, b3, ec3;
  logic       busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
  logic       busy2, done2, pass2, fev2, busy3, done3, pass3, fev3;
  logic [15:0] fei0, fei1, fei2, fei3;
  logic [7:0] p1_1, p1_2, p2_1, p2_2;

  assign s0 = stuck ? (8'(a0 + b0) & 8'hFE) : 8'(a0 + b0);
  assign s1 = p1_2;
  assign s2 = p2_2;

  always_ff @(posedge clk) begin
    p1_1 <= 8'(a1 + b1);
    p1_2 <= p1_1;
    p2_1 <= 8'(a2 + b2);
    p2_2 <= p2_1;
  end

  adder_pin_exerciser #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(256), .SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .start(start), .op_a(a0), .op_b(b0), .sum_in(s0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .first_err_valid(fev0), .first_err_idx(fei0));
  adder_pin_exerciser #(.WIDTH(8), .LATENCY(2), .NUM_VECTORS(256), .SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op_a(a1), .op_b(b1), .sum_in(s1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err_valid(fev1), .first_err_idx(fei1));
  adder_pin_exerciser #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(256), .SEED(16'hACE1)) u2 (
    .clk(clk), .rst(rst), .start(start), .op_a(a2), .op_b(b2), .sum_in(s2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
    .first_err_valid(fev2), .first_err_idx(fei2));
  adder_pin_exerciser #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(300), .SEED(16'hACE1)) u3 (
    .clk(clk), .rst(rst), .start(start), .op_a(a3), .op_b(b3), .sum_in(8'd0),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3),
    .first_err_valid(fev3), .first_err_idx(fei3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR written out tap by tap: taps 16,14,13,11 -> bits 15,13,12,10
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Walks n vectors from the seed: odd sums (bit0-stuck errors), nonzero sums
  task automatic ref_run(input int n, output int odd_cnt, output int first_odd,
                         output int nz_cnt, output int first_nz);
    logic [15:0] s;
    logic [7:0]  sum;
    s = 16'hACE1; odd_cnt = 0; first_odd = -1; nz_cnt = 0; first_nz = -1;
    for (int i = 0; i < n; i++) begin
      sum = 8'(s[15:8] + s[7:0]);
      if (sum[0]) begin
        if (first_odd < 0) first_odd = i;
        odd_cnt++;
      end
      if (sum != 8'd0) begin
        if (first_nz < 0) first_nz = i;
        nz_cnt++;
      end
      s = ref_step(s);
    end
  endtask

  task automatic wait_done0(input int bound, output int cyc);
    cyc = 0;
    while (!done0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    int odd256, fodd256, nz256, fnz256, odd300, fodd300, nz300, fnz300;
    int t0, t1, t2, t3, cyc;
    int exp_odd, exp_sat;
    logic [15:0] s_next;
    logic [7:0]  a_v1, b_v1;

    ref_run(256, odd256, fodd256, nz256, fnz256);
    ref_run(300, odd300, fodd300, nz300, fnz300);
    exp_odd = (odd256 > 255) ? 255 : odd256;
    exp_sat = (nz300 > 255) ? 255 : nz300;
    s_next  = ref_step(16'hACE1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ops", {16'd0, a0, b0}, 32'd0);
    check("rst_flags", {28'd0, busy0, done0, pass0, fev0}, 32'd0);
    check("rst_err", {8'd0, ec0, fei0}, 32'd0);
    rst = 1'b0;

    // Clean loopback on u0, latency cases on u1/u2, saturation on u3
    pulse_start();
    check("clean_op_a0", {24'd0, a0}, 32'h000000AC);
    check("clean_op_b0", {24'd0, b0}, 32'h000000E1);
    check("clean_busy", {31'd0, busy0}, 32'd1);
    t0 = 0; t1 = 0; t2 = 0; t3 = 0; a_v1 = 8'd0; b_v1 = 8'd0;
    for (int c = 1; c <= 1500 && t1 == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin a_v1 = a0; b_v1 = b0; end
      if (done0 && t0 == 0) t0 = c;
      if (done1 && t1 == 0) t1 = c;
      if (done2 && t2 == 0) t2 = c;
      if (done3 && t3 == 0) t3 = c;
    end
    check("clean_op_a1", {24'd0, a_v1}, {24'd0, s_next[15:8]});
    check("clean_op_b1", {24'd0, b_v1}, {24'd0, s_next[7:0]});
    check("clean_done_time", t0, 32'd256);
    check("clean_pass", {31'd0, pass0}, 32'd1);
    check("clean_err", {24'd0, ec0}, 32'd0);
    check("clean_fev", {31'd0, fev0}, 32'd0);
    check("clean_done_ops", {15'd0, busy0, a0, b0}, 32'd0);
    check("lat2_done_time", t1, 32'd768);
    check("lat2_pass", {23'd0, pass1, ec1}, 32'h00000100);
    check("lat2_fev", {15'd0, fev1, fei1}, 32'd0);
    check("lat1_done_time", t2, 32'd512);
    check("lat1_pass", {30'd0, pass2, fev2}, 32'd1);
    check("lat1_err_nonzero", {31'd0, ec2 != 8'd0}, 32'd1);
    check("sat_done_time", t3, 32'd300);
    check("sat_err", {24'd0, ec3}, exp_sat);
    check("sat_pass", {30'd0, pass3, fev3}, 32'd1);
    check("sat_first_idx", {16'd0, fei3}, fnz256);

    // Stuck-at-0 on sum bit 0
    stuck = 1'b1;
    pulse_start();
    wait_done0(1000, cyc);
    check("stuck_done_time", cyc, 32'd256);
    check("stuck_err", {24'd0, ec0}, exp_odd);
    check("stuck_first_idx", {16'd0, fei0}, fodd256);
    check("stuck_flags", {30'd0, pass0, fev0}, 32'd1);

    // Start pulsed mid-run is ignored
    stuck = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done0(1000, cyc);
    check("midstart_done_time", cyc + 6, 32'd256);
    check("midstart_pass", {23'd0, pass0, ec0}, 32'h00000100);

    // Reset during vector 10 (stuck mode so error state is non-empty)
    stuck = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ops", {16'd0, a0, b0}, 32'd0);
    check("midrst_flags", {28'd0, busy0, done0, pass0, fev0}, 32'd0);
    check("midrst_err", {8'd0, ec0, fei0}, 32'd0);
    check("midrst_state", {30'd0, u0.state_r}, {30'd0, IDLE});
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {31'd0, busy0}, 32'd0);
    pulse_start();
    check("midrst_restart_ops", {16'd0, a0, b0}, 32'h0000ACE1);
    wait_done0(1000, cyc);

    // Start held: back-to-back runs, single-cycle done, errors cleared
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done0(1000, cyc);
    check("held_done_time", cyc, 32'd256);
    check("held_err", {24'd0, ec0}, exp_odd);
    @(negedge clk);
    check("held_done_pulse", {30'd0, done0, busy0}, 32'd1);
    check("held_err_clear", {23'd0, fev0, ec0}, 32'd0);
    check("held_restart_ops", {16'd0, a0, b0}, 32'h0000ACE1);
    start = 1'b0;
    wait_done0(1000, cyc);
    check("held_second_done", {31'd0, done0}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_pin_exerciser.md
# adder_pin_exerciser

Self-checking stimulus source for the pin-level adder datapath (sum = a + b, 8-bit, mod 256). It is the driving and checking end of that interface: it generates pseudo-random operand pairs on `op_a`/`op_b`, samples the returned `sum_in` after a configurable latency, and compares it with the expected value. It sits on the host/FPGA side of the tile or in the bench harness, and reports pass/fail plus error statistics.

## Interface
- `WIDTH`, 8: operand and sum width.
- `LATENCY`, 0: cycles between operands becoming valid and `sum_in` being sampled. Range 0..15.
- `NUM_VECTORS`, 256: vectors per run. Range 1..65535.
- `SEED`, 16'hACE1: LFSR start value. Must be non-zero.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. One clock domain only.
- `start` in 1: level-sampled. Accepted in IDLE or DONE.
- `op_a` out WIDTH: operand A driven to the adder.
- `op_b` out WIDTH: operand B driven to the adder.
- `sum_in` in WIDTH: sum returned by the adder.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until restart or reset.
- `pass` out 1: valid when `done`; 1 iff `err_count` == 0.
- `err_count` out 8: mismatches; saturates at 255.
- `first_err_valid` out 1: at least one mismatch seen this run.
- `first_err_idx` out 16: vector index of the first mismatch.

## Operation
- **Reset values:** every output is 0. The FSM goes to IDLE and the LFSR loads `SEED`.
- **States:** IDLE, RUN, DONE.
- **IDLE + `start`:**
  - LFSR loads `SEED`.
  - Vector 0 is loaded: `op_a` = lfsr[15:8], `op_b` = lfsr[7:0].
  - idx = 0, wait = 0.
  - Error state is cleared.
  - `busy` = 1; go to RUN.
- **RUN, wait < `LATENCY`:** wait++.
- **RUN, wait == `LATENCY`:**
  - Compare `sum_in` with expected = (`op_a` + `op_b`) mod 2^WIDTH.
  - On mismatch: `err_count` saturating ++. If this is the first mismatch, `first_err_idx` = idx and `first_err_valid` = 1.
  - If idx == `NUM_VECTORS`-1: go to DONE with `busy` = 0, `done` = 1, `pass` = (final `err_count` == 0), and `op_a`/`op_b` cleared to 0.
  - Otherwise: step the LFSR, load the next operands, idx++, wait = 0.
- **LFSR:** 16-bit Fibonacci, taps 16, 14, 13, 11. Shifts left, feedback enters bit 0.
- **Operand width:** operands take the top and bottom WIDTH bits of the LFSR state (WIDTH ≤ 8). The sum is truncated; carry is ignored.
- **`start` in RUN:** ignored.
- **`start` in DONE:** same action as from IDLE. `done`, `pass`, and the error state clear on the same edge.
- **`start` held continuously:** back-to-back runs. `done` is high for exactly 1 cycle between runs.
- **`rst` mid-run:** aborts the run. All outputs are 0 on the next cycle. The error state is lost.

## Timing
- Each operand pair is held stable for `LATENCY`+1 cycles. `sum_in` is sampled on the last of those cycles.
- With `LATENCY` = 0, `sum_in` is sampled in the same cycle the operands are visible, which requires a combinational adder.
- The `start` edge loads vector 0. `done` rises `NUM_VECTORS`×(`LATENCY`+1) cycles later.
- `err_count` and `first_err_*` update 1 cycle after the compare cycle.
- `pass` and `done` rise on the same edge. `pass` includes the final vector's result.

## Structure
- Package `adder_exerciser_pkg`:
  - state enum (IDLE, RUN, DONE)
  - LFSR tap mask constant 16'hB400
  - default `SEED`
  - `ERR_SAT` = 255
- Sub-module `lfsr16`:
  - inputs: `load`, `seed`, `step`
  - output: `state`
  - synchronous active-high reset to `seed`
- The top level holds the FSM, counters, compare, and error capture.

## Test plan
- **Clean loopback:** `sum_in` = `op_a` + `op_b` combinationally, `LATENCY` = 0, `NUM_VECTORS` = 256, pulse `start`.
  - The first operands are `op_a` = 8'hAC, `op_b` = 8'hE1.
  - `done` rises 256 cycles later with `pass` = 1, `err_count` = 0, `first_err_valid` = 0.
- **Stuck-at fault:** loopback with `sum_in`[0] forced to 0.
  - `err_count` = the number of odd expected sums, computed by the reference model.
  - `first_err_idx` = index of the first odd sum.
  - `pass` = 0.
- **Latency mismatch:** 2-stage registered adder.
  - `LATENCY` = 2 gives `pass` = 1.
  - `LATENCY` = 1 gives `pass` = 0 and `err_count` > 0.
- **Saturation:** `sum_in` tied to 0, `NUM_VECTORS` = 300 → `err_count` = 255 at `done`, not wrapped.
- **Reset mid-run:** assert `rst` during vector 10.
  - All outputs are 0 on the next cycle and the FSM is in IDLE.
  - A following `start` reproduces `op_a` = 8'hAC, `op_b` = 8'hE1.
- **Start handling:**
  - `start` pulsed during RUN: no effect.
  - `start` held high: back-to-back runs, `done` pulses for 1 cycle, `err_count` clears at restart.
